sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-port 4096×16 `sram` in the CPU. It shares the RAM between instruction fetch (port 0) and data load/store (port 1) with round-robin arbitration. It drives the `sram` chip-enable, write-enable, address and data pins. It returns read data with a valid pulse, hiding the one-cycle registered read and the tri-stated read bus from the requesters.

---
 rtl/sram_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/sram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
//------------------------------------------------------------------------------
// sram_arb_pkg : shared types and constants for the two-port SRAM arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DQ = 1'b1;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_DQ) ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// rr_arb2 : two-requester round-robin grant with next-pointer computation
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  // ptr names the port that wins a tie; a granted port hands the tie to the other
  always_comb begin
    gnt     = 2'b00;
    ptr_nxt = ptr;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = port_onehot(ptr);
      default: gnt = 2'b00;
    endcase
    if (gnt[0]) begin
      ptr_nxt = PORT_DQ;
    end else if (gnt[1]) begin
      ptr_nxt = PORT_IF;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
//------------------------------------------------------------------------------
// sram_arbiter : round-robin arbiter and access sequencer for a 1-port SRAM
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WORD_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WORD_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [WORD_WIDTH-1:0] rdata0,
  output logic [WORD_WIDTH-1:0] rdata1,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0] sram_wdata,
  input  logic [WORD_WIDTH-1:0] sram_rdata
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ptr;
  logic                  w_ptr_nxt;
  logic                  r_port;
  logic                  w_port_nxt;
  logic                  r_ce;
  logic                  w_ce_nxt;
  logic                  r_we;
  logic                  w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic [WORD_WIDTH-1:0] w_wdata_nxt;
  logic [1:0]            r_rvalid;
  logic [1:0]            w_rvalid_nxt;
  logic [WORD_WIDTH-1:0] r_rdata0;
  logic [WORD_WIDTH-1:0] w_rdata0_nxt;
  logic [WORD_WIDTH-1:0] r_rdata1;
  logic [WORD_WIDTH-1:0] w_rdata1_nxt;

  logic [1:0]            w_arb_req;
  logic [1:0]            w_arb_gnt;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [WORD_WIDTH-1:0] w_sel_wdata;

  // Requests are only seen in IDLE; reset masks them so gnt drops with rst_n
  assign w_arb_req = (r_state == ST_IDLE && rst_n) ? {req1, req0} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req     (w_arb_req),
    .ptr     (r_ptr),
    .gnt     (w_arb_gnt),
    .ptr_nxt (w_ptr_nxt)
  );

  assign gnt0 = w_arb_gnt[0];
  assign gnt1 = w_arb_gnt[1];

  assign w_sel_we    = w_arb_gnt[1] ? we1    : we0;
  assign w_sel_addr  = w_arb_gnt[1] ? addr1  : addr0;
  assign w_sel_wdata = w_arb_gnt[1] ? wdata1 : wdata0;

  always_comb begin
    w_state_nxt  = r_state;
    w_port_nxt   = r_port;
    w_ce_nxt     = r_ce;
    w_we_nxt     = r_we;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rvalid_nxt = 2'b00;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;

    case (r_state)
      ST_IDLE: begin
        w_ce_nxt = 1'b0;
        w_we_nxt = 1'b0;
        if (|w_arb_gnt) begin
          w_state_nxt = ST_ACC;
          w_port_nxt  = w_arb_gnt[1] ? PORT_DQ : PORT_IF;
          w_ce_nxt    = 1'b1;
          w_we_nxt    = w_sel_we;
          w_addr_nxt  = w_sel_addr;
          // the write bus is only refreshed by writes
          if (w_sel_we) begin
            w_wdata_nxt = w_sel_wdata;
          end
        end
      end

      ST_ACC: begin
        if (r_we) begin
          w_state_nxt = ST_IDLE;
          w_ce_nxt    = 1'b0;
          w_we_nxt    = 1'b0;
        end else begin
          // keep ce high and the address stable so the SRAM drives its read register
          w_state_nxt = ST_RESP;
          w_ce_nxt    = 1'b1;
          w_we_nxt    = 1'b0;
        end
      end

      ST_RESP: begin
        w_state_nxt  = ST_IDLE;
        w_ce_nxt     = 1'b0;
        w_we_nxt     = 1'b0;
        w_rvalid_nxt = port_onehot(r_port);
        if (r_port == PORT_DQ) begin
          w_rdata1_nxt = sram_rdata;
        end else begin
          w_rdata0_nxt = sram_rdata;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_ce_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= PORT_IF;
      r_port   <= PORT_IF;
      r_ce     <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rvalid <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_port   <= w_port_nxt;
      r_ce     <= w_ce_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
    end
  end

  assign sram_ce    = r_ce;
  assign sram_we    = r_we;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign rvalid0    = r_rvalid[0];
  assign rvalid1    = r_rvalid[1];
  assign rdata0     = r_rdata0;
  assign rdata1     = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
//------------------------------------------------------------------------------
// tb_sram_arbiter : directed bench with a cycle-level reference model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, sram_ce, sram_we;
  logic [DW-1:0] rdata0, rdata1, sram_wdata;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_rdata;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM with a registered read port and a bus that floats unless ce=1, we=0
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] mem_q;
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         mem_q <= mem[sram_addr];
    end
  end
  assign sram_rdata = (sram_ce && !sram_we) ? mem_q : {DW{1'bz}};

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: tracks when the arbiter is free and what each cycle must show
  logic [DW-1:0] mdl_mem [int];
  int            free_at = 0, last = 1, win;
  int            acc_at = -1, resp_at = -1, rv_at = -1, rv_port = 0;
  logic          acc_we = 1'b0;
  logic [AW-1:0] acc_addr = '0;
  logic [DW-1:0] acc_wdata = '0, rv_data = '0, exp_wd = '0;
  logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
  logic          exp_ce;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
      chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      chk("rst_ce_we", 32'({sram_ce, sram_we}), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_wdata", 32'(sram_wdata), 32'd0);
      chk("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
      free_at = 0; last = 1; acc_at = -1; resp_at = -1; rv_at = -1;
      exp_wd = '0; exp_rd0 = '0; exp_rd1 = '0;
    end else begin
      win = -1;
      if (cyc >= free_at) begin
        if (req0 && req1) win = (last == 0) ? 1 : 0;
        else if (req0)    win = 0;
        else if (req1)    win = 1;
      end
      chk("gnt0", 32'(gnt0), 32'(win == 0));
      chk("gnt1", 32'(gnt1), 32'(win == 1));
      exp_ce = (cyc == acc_at) || (cyc == resp_at);
      chk("sram_ce", 32'(sram_ce), 32'(exp_ce));
      chk("sram_we", 32'(sram_we), 32'(cyc == acc_at && acc_we));
      if (exp_ce) chk("sram_addr", 32'(sram_addr), 32'(acc_addr));
      chk("sram_wdata", 32'(sram_wdata), 32'(exp_wd));
      if (cyc == rv_at) begin
        if (rv_port == 0) exp_rd0 = rv_data;
        else              exp_rd1 = rv_data;
      end
      chk("rvalid0", 32'(rvalid0), 32'(cyc == rv_at && rv_port == 0));
      chk("rvalid1", 32'(rvalid1), 32'(cyc == rv_at && rv_port == 1));
      chk("rdata0", 32'(rdata0), 32'(exp_rd0));
      chk("rdata1", 32'(rdata1), 32'(exp_rd1));
      if (cyc == acc_at && acc_we) mdl_mem[int'(acc_addr)] = acc_wdata;
      if (win >= 0) begin
        last      = win;
        acc_at    = cyc + 1;
        acc_we    = (win == 1) ? we1 : we0;
        acc_addr  = (win == 1) ? addr1 : addr0;
        acc_wdata = (win == 1) ? wdata1 : wdata0;
        if (acc_we) begin
          exp_wd  = acc_wdata;
          free_at = cyc + 2;
        end else begin
          resp_at = cyc + 2;
          rv_at   = cyc + 3;
          rv_port = win;
          rv_data = mdl_mem.exists(int'(acc_addr)) ? mdl_mem[int'(acc_addr)] : '0;
          free_at = cyc + 3;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Raise a request, hold it until granted, then drop it; gc returns the grant cycle
  task automatic access(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int gc);
    int budget;
    budget = 0;
    gc = -1;
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    forever begin
      @(negedge clk);
      if ((p == 0 && gnt0) || (p == 1 && gnt1)) begin
        gc = cyc;
        break;
      end
      budget++;
      if (budget > 20) begin
        n_chk++; n_err++;
        $display("FAIL grant_timeout: port %0d got no gnt, required within 20 cycles", p);
        break;
      end
    end
    sync();
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic wait_rv(input int p, input int gc, output int lat);
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((p == 0 && rvalid0) || (p == 1 && rvalid1)) begin
        lat = cyc - gc;
        break;
      end
    end
    sync();
  endtask

  int gc, lat, k, gord_n;
  int gord [4];
  int gc4 [4];
  logic seen;

  initial begin
    repeat (3) sync();
    rst_n = 1'b1;
    sync();

    // Write then read on port 0
    access(0, 1'b1, 12'h123, 16'hBEEF, gc);
    @(negedge clk);
    chk("t1_wr_ce_we", 32'({sram_ce, sram_we}), 32'h3);
    chk("t1_wr_addr", 32'(sram_addr), 32'h123);
    sync();
    access(0, 1'b0, 12'h123, 16'h0000, gc);
    wait_rv(0, gc, lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_rdata0", 32'(rdata0), 32'hBEEF);
    chk("t1_rdata1", 32'(rdata1), 32'h0);

    // Cross-port coherence
    access(1, 1'b1, 12'hFFF, 16'h1234, gc);
    sync();
    access(0, 1'b0, 12'hFFF, 16'h0000, gc);
    wait_rv(0, gc, lat);
    chk("t2_rdata0", 32'(rdata0), 32'h1234);

    // Contention: both read continuously, last grant went to port 1
    access(0, 1'b1, 12'h010, 16'hA0A0, gc);
    sync();
    access(1, 1'b1, 12'h020, 16'hB1B1, gc);
    sync();
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h020;
    gord_n = 0;
    for (int i = 0; i < 30 && gord_n < 4; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) chk("t3_both_gnt", 32'({gnt1, gnt0}), 32'h1);
      if (gnt0) begin gord[gord_n] = 0; gord_n++; end
      else if (gnt1) begin gord[gord_n] = 1; gord_n++; end
    end
    sync();
    req0 = 1'b0; req1 = 1'b0;
    chk("t3_grant_count", 32'(gord_n), 32'd4);
    for (int i = 0; i < gord_n; i++) chk("t3_grant_order", 32'(gord[i]), 32'(i % 2));
    repeat (5) sync();
    chk("t3_rdata0", 32'(rdata0), 32'hA0A0);
    chk("t3_rdata1", 32'(rdata1), 32'hB1B1);

    // Back-to-back writes from port 1 for 8 cycles
    k = 0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h200; wdata1 = 16'h5A00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = gnt1;
      if (gnt1 && k < 4) begin gc4[k] = cyc; k++; end
      sync();
      if (seen) begin addr1 = 12'h200 + AW'(k); wdata1 = 16'h5A00 + DW'(k); end
    end
    req1 = 1'b0;
    chk("t4_write_count", 32'(k), 32'd4);
    for (int i = 1; i < k; i++) chk("t4_gnt_spacing", 32'(gc4[i] - gc4[i-1]), 32'd2);
    sync();
    for (int i = 0; i < 4; i++) begin
      access(0, 1'b0, 12'h200 + AW'(i), 16'h0000, gc);
      wait_rv(0, gc, lat);
      chk("t4_readback", 32'(rdata0), 32'h5A00 + 32'(i));
    end

    // Reset while a read sits in RESP
    access(0, 1'b0, 12'h010, 16'h0000, gc);
    sync();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ctrl", 32'({gnt0, gnt1, rvalid0, rvalid1, sram_ce, sram_we}), 32'd0);
    chk("t5_rst_addr", 32'(sram_addr), 32'd0);
    chk("t5_rst_rdata0", 32'(rdata0), 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h020;
    sync();
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_first_gnt", 32'({gnt1, gnt0}), 32'h1);
    sync();
    req0 = 1'b0; req1 = 1'b0;
    repeat (6) sync();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running, required to finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
